l2_write_buffer: RTL
====================

L2_WRITE_BUFFER -- requirements
Module: l2_write_buffer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, number of 128-bit writeback entries (power of two, 2..8).
REQ-002 SHALL have port: clk  input  1  system clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: mem_read  input  1  line read request from L2 cache, held until mem_resp.
REQ-005 SHALL have port: mem_write  input  1  line writeback request from L2 cache, held until mem_resp.
REQ-006 SHALL have port: mem_address  input  16  line address; bits [3:0] are ignored.
REQ-007 SHALL have port: mem_wdata  input  128  writeback line data.
REQ-008 SHALL have port: mem_resp  output  1  one-cycle completion pulse to L2.
REQ-009 SHALL have port: mem_rdata  output  128  read line data, valid while mem_resp=1.
REQ-010 SHALL have port: pmem_read  output  1  read request to physical memory.
REQ-011 SHALL have port: pmem_write  output  1  write request to physical memory.
REQ-012 SHALL have port: pmem_address  output  16  physical line address, bits [3:0]=0.
REQ-013 SHALL have port: pmem_wdata  output  128  physical write data.
REQ-014 SHALL have port: pmem_resp  input  1  physical memory completion.
REQ-015 SHALL have port: pmem_rdata  input  128  physical read data, valid with pmem_resp.

Function
REQ-016 SHALL hold a FIFO of DEPTH entries {tag=address[15:4], data[127:0], valid}, with head/tail pointers wrapping modulo DEPTH and a count from 0 to DEPTH.
REQ-017 SHALL use FSM states IDLE, READ, DRAIN, RESP; on leaving reset the FSM is in IDLE.
REQ-018 SHALL, in IDLE with mem_write=1 and a tag match on a non-head entry (or on the head entry while no drain is active), overwrite that entry's data (coalesce) without changing count, then enter RESP.
REQ-019 SHALL, in IDLE with mem_write=1, no coalesce and count<DEPTH, enqueue at tail, then enter RESP.
REQ-020 SHALL, when mem_write=1 and count=DEPTH with no coalesce, withhold mem_resp and start or continue a drain; the write is accepted in the first IDLE cycle after count drops.
REQ-021 SHALL, in IDLE with mem_read=1 and no tag match, drive pmem_read=1 with pmem_address={address[15:4],4'b0} and enter READ; mem_read takes priority over starting a drain.
REQ-022 SHALL, in READ on pmem_resp=1, capture pmem_rdata and enter RESP.
REQ-023 SHALL, in RESP, assert mem_resp=1 for exactly one cycle, then return to IDLE; requests are ignored in the RESP cycle.
REQ-024 SHALL, in IDLE with no acceptable L2 request and count>0, drive pmem_write=1 with the head entry and enter DRAIN; in DRAIN on pmem_resp=1, pop the head and return to IDLE.
REQ-025 SHALL NOT abort an in-progress DRAIN or READ; a new request waits until IDLE.
REQ-026 SHALL hold pmem_address/pmem_wdata stable while pmem_read or pmem_write is 1 and never assert both.
REQ-027 SHALL give write-to-mem_resp latency of 2 cycles when not full, and read-miss latency of pmem latency +2 cycles.

Reset
REQ-028 SHALL, on reset assertion at any time, asynchronously clear all valid bits, pointers and count, set the FSM to IDLE and drive mem_resp, pmem_read and pmem_write to 0, with mem_rdata and pmem_address at 0; buffered data is discarded.

Configuration
REQ-029 SHALL, with WB_READ_FORWARD_EN defined, service a read whose tag matches a buffered entry from that entry: RESP is entered next cycle and mem_rdata = entry data, with no pmem access.
REQ-030 SHALL, without WB_READ_FORWARD_EN, on a read tag match, drain entries until the matching entry is popped, then issue the pmem read.

Structure
REQ-031 SHALL place typedefs lc3b_line (128-bit) and lc3b_wb_entry (tag, data, valid) in package lc3b_types.
REQ-032 SHALL implement storage plus parallel tag compare in one sub-module, wb_entry_array, exposing a match flag and match index.

Verification
REQ-033 SHALL cover: write 0x1230 data A with pmem idle -> mem_resp at cycle 2; later pmem_write addr 0x1230, data A.
REQ-034 SHALL cover: DEPTH=4, five writes 0x0000/0x0010/0x0020/0x0030/0x0040 with pmem_resp delayed 10 cycles -> 5th mem_resp only after the first drain's pmem_resp.
REQ-035 SHALL cover: write 0x0100 data A then 0x0100 data B before drain -> count stays 1; single pmem_write with data B.
REQ-036 SHALL cover: buffered 0x0200 data C, then read 0x0200 -> C at cycle 2 with no pmem_read (WB_READ_FORWARD_EN), or pmem_write 0x0200 precedes pmem_read 0x0200 (macro absent).
REQ-037 SHALL cover: reset asserted mid-DRAIN with 3 entries -> pmem_write=0 immediately; no pmem activity afterwards until a new request.

Source files
------------

// File: rtl/l2_write_buffer_pkg.sv
// Shared types for the L2 writeback buffer: line/tag typedefs, buffer entry
// payload, FSM state encoding and a tag-to-line-address helper.
package lc3b_types;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OFFS_W = 4;
  localparam int unsigned TAG_W  = ADDR_W - OFFS_W;

  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [TAG_W-1:0]  lc3b_tag;

  typedef struct packed {
    lc3b_tag  tag;
    lc3b_line data;
    logic     valid;
  } lc3b_wb_entry;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_READ  = 2'd1,
    WB_DRAIN = 2'd2,
    WB_RESP  = 2'd3
  } wb_state_e;

  // Line-aligned physical address for a tag (offset bits forced to zero).
  function automatic logic [ADDR_W-1:0] line_addr(input lc3b_tag tag);
    return {tag, {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/wb_entry_array.sv
// Writeback entry storage with a parallel tag compare.
// Ports: clk/reset; wr_* write (enqueue or coalesce) one entry; clr_* drops
// the valid bit of a popped entry; lookup_tag is compared against all valid
// entries giving match_c/match_idx_c/match_data_c; head_idx selects the entry
// presented on head_tag_c/head_data_c for draining.
module wb_entry_array
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  lc3b_tag          wr_tag,
  input  lc3b_line         wr_data,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  lc3b_tag          lookup_tag,
  output logic             match_c,
  output logic [IDX_W-1:0] match_idx_c,
  output lc3b_line         match_data_c,
  input  logic [IDX_W-1:0] head_idx,
  output lc3b_tag          head_tag_c,
  output lc3b_line         head_data_c
);

  lc3b_wb_entry entries [DEPTH];

  // Entry storage; write and clear never target the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[IDX_W'(i)] <= '0;
      end
    end else begin
      if (clr_en) begin
        entries[clr_idx].valid <= 1'b0;
      end
      if (wr_en) begin
        entries[wr_idx] <= '{tag: wr_tag, data: wr_data, valid: 1'b1};
      end
    end
  end

  // Coalescing keeps tags unique, so at most one entry can hit.
  always_comb begin
    match_c     = 1'b0;
    match_idx_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entries[IDX_W'(i)].valid && (entries[IDX_W'(i)].tag == lookup_tag)) begin
        match_c     = 1'b1;
        match_idx_c = IDX_W'(i);
      end
    end
  end

  assign match_data_c = entries[match_idx_c].data;
  assign head_tag_c   = entries[head_idx].tag;
  assign head_data_c  = entries[head_idx].data;

endmodule

// File: rtl/l2_write_buffer.sv
// Writeback buffer between the L2 cache and physical memory. L2 writebacks
// are queued (or coalesced onto a buffered line with the same tag) and acked
// quickly; queued lines drain to memory whenever L2 is quiet or the queue is
// full. Read misses go straight to memory ahead of pending drains.
// Ports: clk, reset (async, active high); L2 side mem_read/mem_write/
// mem_address/mem_wdata in, mem_resp/mem_rdata out; memory side pmem_read/
// pmem_write/pmem_address/pmem_wdata out, pmem_resp/pmem_rdata in.
// Build option: WB_READ_FORWARD_EN serves reads that hit a buffered line
// directly from the buffer; without it the buffer drains past the hit first.
module l2_write_buffer
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [ADDR_W-1:0]   mem_address,
  input  logic [LINE_W-1:0]   mem_wdata,
  output logic                mem_resp,
  output logic [LINE_W-1:0]   mem_rdata,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic [LINE_W-1:0]   pmem_wdata,
  input  logic                pmem_resp,
  input  logic [LINE_W-1:0]   pmem_rdata
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_state_e        state, next_state;
  logic [IDX_W-1:0] head, tail, wr_idx;
  logic [CNT_W-1:0] count;
  logic             full, wr_en, enq, pop;
  lc3b_tag          req_tag, head_tag_c;
  logic             match_c;
  logic [IDX_W-1:0] match_idx_c;
  lc3b_line         match_data_c, head_data_c;

  logic             mem_resp_d, pmem_read_d, pmem_write_d;
  logic [ADDR_W-1:0] pmem_address_d;
  lc3b_line         pmem_wdata_d, mem_rdata_d;

  logic             unused_addr_lo;

  assign req_tag        = mem_address[ADDR_W-1:OFFS_W];
  assign full           = (count == CNT_W'(DEPTH));
  assign unused_addr_lo = ^mem_address[OFFS_W-1:0];

  wb_entry_array #(.DEPTH(DEPTH)) u_entries (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_idx       (wr_idx),
    .wr_tag       (req_tag),
    .wr_data      (mem_wdata),
    .clr_en       (pop),
    .clr_idx      (head),
    .lookup_tag   (req_tag),
    .match_c      (match_c),
    .match_idx_c  (match_idx_c),
    .match_data_c (match_data_c),
    .head_idx     (head),
    .head_tag_c   (head_tag_c),
    .head_data_c  (head_data_c)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state: writes first, then reads, then background drain.
  always_comb begin
    next_state = state;
    case (state)
      WB_IDLE: begin
        if (mem_write) begin
          // A full buffer with no coalesce target must drain before accepting.
          next_state = (match_c || !full) ? WB_RESP : WB_DRAIN;
        end else if (mem_read) begin
`ifdef WB_READ_FORWARD_EN
          next_state = match_c ? WB_RESP : WB_READ;
`else
          // Memory would return stale data; drain until the hit is gone.
          next_state = match_c ? WB_DRAIN : WB_READ;
`endif
        end else if (count != '0) begin
          next_state = WB_DRAIN;
        end
      end
      WB_READ:  if (pmem_resp) next_state = WB_RESP;
      WB_DRAIN: if (pmem_resp) next_state = WB_IDLE;
      WB_RESP:  next_state = WB_IDLE;
      default:  next_state = WB_IDLE;
    endcase
  end

  // Output/datapath decode; pmem request fields hold unless a transition
  // starts or finishes a memory transaction.
  always_comb begin
    wr_en          = 1'b0;
    wr_idx         = tail;
    enq            = 1'b0;
    pop            = 1'b0;
    mem_resp_d     = (next_state == WB_RESP);
    mem_rdata_d    = mem_rdata;
    pmem_read_d    = pmem_read;
    pmem_write_d   = pmem_write;
    pmem_address_d = pmem_address;
    pmem_wdata_d   = pmem_wdata;
    case (state)
      WB_IDLE: begin
        case (next_state)
          WB_RESP: begin
            if (mem_write) begin
              wr_en  = 1'b1;
              wr_idx = match_c ? match_idx_c : tail;
              enq    = !match_c;
            end else begin
              // Only reachable when read forwarding is built in.
              mem_rdata_d = match_data_c;
            end
          end
          WB_READ: begin
            pmem_read_d    = 1'b1;
            pmem_address_d = line_addr(req_tag);
          end
          WB_DRAIN: begin
            pmem_write_d   = 1'b1;
            pmem_address_d = line_addr(head_tag_c);
            pmem_wdata_d   = head_data_c;
          end
          default: ;
        endcase
      end
      WB_READ: begin
        if (pmem_resp) begin
          pmem_read_d = 1'b0;
          mem_rdata_d = pmem_rdata;
        end
      end
      WB_DRAIN: begin
        if (pmem_resp) begin
          pmem_write_d = 1'b0;
          pop          = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      mem_resp     <= mem_resp_d;
      mem_rdata    <= mem_rdata_d;
      pmem_read    <= pmem_read_d;
      pmem_write   <= pmem_write_d;
      pmem_address <= pmem_address_d;
      pmem_wdata   <= pmem_wdata_d;
    end
  end

  // Queue pointers and occupancy; enqueue (IDLE) and pop (DRAIN) are exclusive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail  <= tail + IDX_W'(1);
        count <= count + CNT_W'(1);
      end
      if (pop) begin
        head  <= head + IDX_W'(1);
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule
